// File: rtl/fixed_vec_recip_if.sv
`default_nettype none
// ============================================================================
// fixed_vec_recip_if : valid/ready input and result bus for fixed_vec_recip
// Rev 1.0
// ============================================================================
interface fixed_vec_recip_if #(
  parameter int LANES = 3,
  parameter int W     = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [LANES*W-1:0] in_vec;
  logic               out_valid;
  logic               out_ready;
  logic [LANES*W-1:0] out_vec;
  logic [LANES-1:0]   out_zdiv;
  logic [LANES-1:0]   out_ovf;

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_vec, out_zdiv, out_ovf
  );

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_vec, out_zdiv, out_ovf
  );
endinterface
`default_nettype wire

// File: rtl/fixed_vec_recip.sv
`default_nettype none
// ============================================================================
// fixed_vec_recip : per-lane 1/v in signed fixed point, iterative restoring
//                   division. FIXED_RECIP_SATURATE_EN saturates bad lanes.
// Rev 1.0
// ============================================================================
module fixed_vec_recip #(
  parameter int LANES = 3,
  parameter int W     = 32,
  parameter int FRAC  = 16
) (
  input  wire logic        clk,
  input  wire logic        resetn,
  fixed_vec_recip_if.slave bus,
  output logic             busy
);

  localparam int DW = 2 * FRAC + 1;
  localparam int CW = $clog2(DW);
  localparam int XW = 2 * W;

  localparam logic [XW-1:0] C_POS_LIM = {{(XW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic [XW-1:0] C_NEG_LIM = {{(XW-W){1'b0}}, 1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]  C_SAT_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  C_SAT_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic          w_accept;
  logic          w_dbit;

  assign bus.in_ready  = (r_state == S_IDLE) && resetn;
  assign bus.out_valid = (r_state == S_DONE);
  assign busy          = (r_state != S_IDLE);
  assign w_accept      = bus.in_valid && bus.in_ready;
  // Dividend is 2^(2*FRAC): only its top bit (first step) is set.
  assign w_dbit        = (r_cnt == CW'(DW - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_PREP;
      S_PREP:  w_state_nxt = S_ITER;
      S_ITER:  if (r_cnt == '0) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_DONE;
      S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (r_state == S_PREP) begin
      r_cnt <= CW'(DW - 1);
    end else if (r_state == S_ITER) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [W-1:0]  r_vin;
    logic [W-1:0]  r_abs;
    logic [W-2:0]  r_rem;
    logic [DW-1:0] r_q;
    logic          r_neg;
    logic          r_zero;
    logic [W-1:0]  r_ov;
    logic          r_zf;
    logic          r_of;

    logic [W-1:0]  w_shift;
    logic          w_ge;
    logic [W-2:0]  w_rem_nxt;
    logic [XW-1:0] w_qx;
    logic [W-1:0]  w_mag;
    logic          w_ovf;
    logic [W-1:0]  w_res;
    logic [W-1:0]  w_bad;
    logic [W-1:0]  w_out;

    // Remainder stays below |v| <= 2^(W-1), so W-1 bits hold it.
    always_comb begin
      w_shift   = {r_rem, w_dbit};
      w_ge      = (w_shift >= r_abs);
      w_rem_nxt = (W-1)'(w_ge ? (w_shift - r_abs) : w_shift);
      w_qx      = XW'(r_q);
      w_mag     = w_qx[W-1:0];
      w_ovf     = !r_zero && (r_neg ? (w_qx > C_NEG_LIM) : (w_qx > C_POS_LIM));
      w_res     = r_neg ? (~w_mag + W'(1)) : w_mag;
`ifdef FIXED_RECIP_SATURATE_EN
      w_bad     = r_neg ? C_SAT_NEG : C_SAT_POS;
`else
      w_bad     = '0;
`endif
      w_out     = (r_zero || w_ovf) ? w_bad : w_res;
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_vin  <= '0;
        r_abs  <= '0;
        r_rem  <= '0;
        r_q    <= '0;
        r_neg  <= 1'b0;
        r_zero <= 1'b0;
        r_ov   <= '0;
        r_zf   <= 1'b0;
        r_of   <= 1'b0;
      end else if (r_state == S_IDLE) begin
        if (w_accept) r_vin <= bus.in_vec[gi*W +: W];
      end else if (r_state == S_PREP) begin
        r_neg  <= r_vin[W-1];
        r_zero <= (r_vin == '0);
        r_abs  <= r_vin[W-1] ? (~r_vin + W'(1)) : r_vin;
        r_rem  <= '0;
        r_q    <= '0;
      end else if (r_state == S_ITER) begin
        r_rem  <= w_rem_nxt;
        r_q    <= {r_q[DW-2:0], w_ge};
      end else if (r_state == S_FIX) begin
        r_ov   <= w_out;
        r_zf   <= r_zero;
        r_of   <= w_ovf;
      end
    end

    assign bus.out_vec[gi*W +: W] = r_ov;
    assign bus.out_zdiv[gi]       = r_zf;
    assign bus.out_ovf[gi]        = r_of;
  end

  // C_SAT_* are only referenced in the saturating build.
`ifndef FIXED_RECIP_SATURATE_EN
  logic w_sat_unused;
  assign w_sat_unused = ^{C_SAT_POS, C_SAT_NEG};
`endif

endmodule
`default_nettype wire
